// File: rtl/turn_ctrl_fsm.sv
// Turn controller for the throwing game: selects the active key source, measures
// charge power while the key is held, runs the throw window and hands the turn on.
module turn_ctrl_fsm #(
  parameter int CLK_HZ         = 65000000,
  parameter int THROW_MS       = 1000,
  parameter int NUM_PLAYERS    = 2,
  parameter int LOCAL_ID       = 0,
  parameter int POWER_W        = 8,
  parameter int POWER_STEP_CYC = 650000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           space,
  input  logic                           space_rx,
  input  logic                           hit,
  output logic                           enable_draw,
  output logic [1:0]                     index,
  output logic                           space_pin_tx,
  output logic                           throw_enable,
  output logic [POWER_W-1:0]             power,
  output logic [$clog2(NUM_PLAYERS)-1:0] player,
  output logic                           turn_done
);

  localparam int THROW_CYC = CLK_HZ / 1000 * THROW_MS;
  localparam int TW        = (THROW_CYC > 1) ? $clog2(THROW_CYC) : 1;
  localparam int SW        = (POWER_STEP_CYC > 1) ? $clog2(POWER_STEP_CYC) : 1;
  localparam int PW        = $clog2(NUM_PLAYERS);

  localparam logic [TW-1:0]      THROW_LAST  = TW'(THROW_CYC - 1);
  localparam logic [SW-1:0]      STEP_LAST   = SW'(POWER_STEP_CYC - 1);
  localparam logic [PW-1:0]      LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [PW-1:0]      LOCAL_P     = PW'(LOCAL_ID);
  localparam logic [POWER_W-1:0] POWER_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_CHARGE = 3'd2,
    S_THROW  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       step_q, step_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [POWER_W-1:0]  power_q, power_d;
  logic [PW-1:0]       player_q, player_d;
  logic [1:0]          index_q, index_d;
  logic                enable_draw_q, enable_draw_d;
  logic                space_pin_tx_q, space_pin_tx_d;
  logic                throw_enable_q, throw_enable_d;
  logic                turn_done_q, turn_done_d;
  logic                act_space;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    state_d  = state_q;
    step_d   = step_q;
    tcnt_d   = tcnt_q;
    power_d  = power_q;
    player_d = player_q;
    act_space = (player_q == LOCAL_P) ? space : space_rx;

    case (state_q)
      S_IDLE: if (!act_space) state_d = S_READY;
      S_READY: begin
        if (act_space) begin
          state_d = S_CHARGE;
          step_d  = '0;
          power_d = '0;
        end
      end
      S_CHARGE: begin
        // The release cycle still counts toward power; it freezes once in THROW.
        if (step_q == STEP_LAST) begin
          step_d = '0;
          if (power_q != POWER_MAX) power_d = power_q + POWER_W'(1);
        end else begin
          step_d = step_q + SW'(1);
        end
        if (!act_space) begin
          state_d = S_THROW;
          tcnt_d  = '0;
        end
      end
      S_THROW: begin
        if (hit || tcnt_q == THROW_LAST) state_d = S_DONE;
        else                             tcnt_d  = tcnt_q + TW'(1);
      end
      S_DONE: begin
        state_d  = S_IDLE;
        player_d = (player_q == LAST_PLAYER) ? '0 : player_q + PW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear with the transition.
    case (state_d)
      S_CHARGE: index_d = 2'd1;
      S_THROW:  index_d = 2'd2;
      S_DONE:   index_d = 2'd3;
      default:  index_d = 2'd0;
    endcase
    enable_draw_d  = (state_d == S_CHARGE);
    space_pin_tx_d = (state_d == S_CHARGE) && (player_d == LOCAL_P);
    throw_enable_d = (state_d == S_THROW);
    turn_done_d    = (state_d == S_DONE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      step_q         <= '0;
      tcnt_q         <= '0;
      power_q        <= '0;
      player_q       <= '0;
      index_q        <= '0;
      enable_draw_q  <= 1'b0;
      space_pin_tx_q <= 1'b0;
      throw_enable_q <= 1'b0;
      turn_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      tcnt_q         <= tcnt_d;
      power_q        <= power_d;
      player_q       <= player_d;
      index_q        <= index_d;
      enable_draw_q  <= enable_draw_d;
      space_pin_tx_q <= space_pin_tx_d;
      throw_enable_q <= throw_enable_d;
      turn_done_q    <= turn_done_d;
    end
  end

  assign enable_draw  = enable_draw_q;
  assign index        = index_q;
  assign space_pin_tx = space_pin_tx_q;
  assign throw_enable = throw_enable_q;
  assign power        = power_q;
  assign player       = player_q;
  assign turn_done    = turn_done_q;

endmodule

// File: tb/tb_turn_ctrl_fsm.sv
// Randomized bench for turn_ctrl_fsm: each turn is described by hold length, hit
// position and pre-hold, and the expected output trace is derived from those numbers.
module tb_turn_ctrl_fsm;

  localparam int CLK_HZ         = 1000;
  localparam int THROW_MS       = 5;
  localparam int NUM_PLAYERS    = 2;
  localparam int LOCAL_ID       = 0;
  localparam int POWER_W        = 3;
  localparam int POWER_STEP_CYC = 2;
  localparam int THROW_CYC      = CLK_HZ / 1000 * THROW_MS;
  localparam int PMAX           = (1 << POWER_W) - 1;
  localparam int NO_HIT         = 99;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           space, space_rx, hit;
  logic                           enable_draw, space_pin_tx, throw_enable, turn_done;
  logic [1:0]                     index;
  logic [POWER_W-1:0]             power;
  logic [$clog2(NUM_PLAYERS)-1:0] player;

  int total = 0;
  int bad   = 0;
  int m_player = 0;
  int m_power  = 0;

  turn_ctrl_fsm #(
    .CLK_HZ(CLK_HZ), .THROW_MS(THROW_MS), .NUM_PLAYERS(NUM_PLAYERS),
    .LOCAL_ID(LOCAL_ID), .POWER_W(POWER_W), .POWER_STEP_CYC(POWER_STEP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .space(space), .space_rx(space_rx), .hit(hit),
    .enable_draw(enable_draw), .index(index), .space_pin_tx(space_pin_tx),
    .throw_enable(throw_enable), .power(power), .player(player), .turn_done(turn_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  // Drives the key of the turn owner with act and the other key with noise.
  task automatic drive(input bit act, input bit h);
    bit noise = 1'($urandom_range(0, 1));
    if (m_player == LOCAL_ID) begin
      space    = act;
      space_rx = noise;
    end else begin
      space_rx = act;
      space    = noise;
    end
    hit = h;
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // idx: 0 idle/ready, 1 charging, 2 throwing, 3 turn end.
  task automatic expect_outs(input string tag, input int idx);
    check({tag, ".index"},  32'(index),        32'(idx));
    check({tag, ".draw"},   32'(enable_draw),  32'(idx == 1));
    check({tag, ".pin_tx"}, 32'(space_pin_tx), 32'(idx == 1 && m_player == LOCAL_ID));
    check({tag, ".throw"},  32'(throw_enable), 32'(idx == 2));
    check({tag, ".done"},   32'(turn_done),    32'(idx == 3));
    check({tag, ".power"},  32'(power),        32'(m_power));
    check({tag, ".player"}, 32'(player),       32'(m_player));
  endtask

  // One turn starting from IDLE: key held pre_hold cycles (must be ignored),
  // released one cycle, held for `hold` cycles, then a throw ended by a hit on
  // throw cycle hit_at or by the window expiring.
  task automatic run_turn(input int hold, input int hit_at, input int pre_hold, input bit abort);
    int len;
    for (int k = 0; k < pre_hold; k++) begin
      drive(1'b1, 1'($urandom_range(0, 1)));
      step();
      expect_outs("idle_hold", 0);
    end
    drive(1'b0, 1'($urandom_range(0, 1)));
    step();
    expect_outs("ready", 0);
    for (int i = 1; i <= hold; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)));
      step();
      m_power = sat((i - 1) / POWER_STEP_CYC);
      expect_outs("charge", 1);
    end
    drive(1'b0, 1'($urandom_range(0, 1)));
    step();
    m_power = sat(hold / POWER_STEP_CYC);
    expect_outs("throw_start", 2);
    if (abort) begin
      #1 rst_n = 1'b0;
      #1;
      m_player = 0;
      m_power  = 0;
      expect_outs("async_rst", 0);
      step();
      expect_outs("in_rst", 0);
      rst_n = 1'b1;
      return;
    end
    len = (hit_at < THROW_CYC) ? hit_at : THROW_CYC;
    for (int j = 1; j < len; j++) begin
      drive(1'($urandom_range(0, 1)), 1'b0);
      step();
      expect_outs("throw", 2);
    end
    drive(1'($urandom_range(0, 1)), 1'(hit_at <= THROW_CYC));
    step();
    expect_outs("done", 3);
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step();
    m_player = (m_player + 1) % NUM_PLAYERS;
    expect_outs("idle", 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    space    = 1'b0;
    space_rx = 1'b0;
    hit      = 1'b0;
    #12;
    expect_outs("reset", 0);
    #10 rst_n = 1'b1;

    run_turn(6, NO_HIT, 0, 1'b0);   // local turn, power 3, player -> 1
    run_turn(4, NO_HIT, 0, 1'b0);   // remote turn, power 2, player wraps to 0
    run_turn(20, NO_HIT, 0, 1'b0);  // saturation at 7, held until next charge
    run_turn(3, 2, 0, 1'b0);        // hit on second throw cycle
    run_turn(2, NO_HIT, 3, 1'b0);   // key still held on return to IDLE
    run_turn(1, NO_HIT, 0, 1'b0);   // one-cycle press
    run_turn(2, THROW_CYC, 0, 1'b0);// hit together with terminal count
    run_turn(5, NO_HIT, 0, 1'b1);   // asynchronous reset mid-throw
    run_turn(3, NO_HIT, 0, 1'b0);   // resumes from IDLE after reset

    for (int t = 0; t < 40; t++) begin
      run_turn(int'($urandom_range(1, 20)), int'($urandom_range(1, THROW_CYC + 2)),
               int'($urandom_range(0, 2)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
